// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID (addr 0) and build timestamp
// (addr 1) words and flags any mismatch against build-time expected values.
module nios_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1523017966,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned RECHECK_PERIOD     = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic        id_match,
   output logic        ts_match,
   output logic        timeout,
   output logic        error,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned STALL_W = 16;
   localparam int unsigned LAT_W   = 2;
   localparam int unsigned RC_W    = 32;

   localparam bit LAT_EN     = (READ_LATENCY != 32'd0);
   localparam bit RECHECK_EN = (RECHECK_PERIOD != 32'd0);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [LAT_W-1:0]   LAT_LAST   =
      LAT_W'(LAT_EN ? (READ_LATENCY - 32'd1) : 32'd0);
   localparam logic [RC_W-1:0]    RC_LAST    =
      RC_W'(RECHECK_EN ? (RECHECK_PERIOD - 32'd1) : 32'd0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_LAT_ID,
      S_RD_TS,
      S_LAT_TS
   } state_t;

   state_t              r_state;
   logic                r_auto;
   logic [STALL_W-1:0]  r_stall_cnt;
   logic [LAT_W-1:0]    r_lat_cnt;
   logic [RC_W-1:0]     r_rc_cnt;
   logic                r_m_read;
   logic                r_m_address;
   logic                r_busy;
   logic                r_done;
   logic                r_valid;
   logic                r_id_match;
   logic                r_ts_match;
   logic                r_timeout;
   logic                r_error;
   logic [DATA_W-1:0]   r_id_value;
   logic [DATA_W-1:0]   r_ts_value;

   state_t              w_nxt_state;
   logic                w_nxt_auto;
   logic [STALL_W-1:0]  w_nxt_stall_cnt;
   logic [LAT_W-1:0]    w_nxt_lat_cnt;
   logic [RC_W-1:0]     w_nxt_rc_cnt;
   logic                w_nxt_m_read;
   logic                w_nxt_m_address;
   logic                w_nxt_busy;
   logic                w_nxt_done;
   logic                w_nxt_valid;
   logic                w_nxt_id_match;
   logic                w_nxt_ts_match;
   logic                w_nxt_timeout;
   logic                w_nxt_error;
   logic [DATA_W-1:0]   w_nxt_id_value;
   logic [DATA_W-1:0]   w_nxt_ts_value;

   logic                w_rc_hit;
   logic                w_cap_id;
   logic                w_cap_ts;
   logic                w_id_ok;
   logic                w_ts_ok;

   assign w_rc_hit = RECHECK_EN && r_valid && (r_rc_cnt == RC_LAST);
   assign w_id_ok  = (r_id_value == EXPECTED_ID);
   assign w_ts_ok  = (m_readdata == EXPECTED_TIMESTAMP);

   // State and result registers; reset drops the bus strobe immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_auto      <= 1'b1;
         r_stall_cnt <= '0;
         r_lat_cnt   <= '0;
         r_rc_cnt    <= '0;
         r_m_read    <= 1'b0;
         r_m_address <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_valid     <= 1'b0;
         r_id_match  <= 1'b0;
         r_ts_match  <= 1'b0;
         r_timeout   <= 1'b0;
         r_error     <= 1'b0;
         r_id_value  <= '0;
         r_ts_value  <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_auto      <= w_nxt_auto;
         r_stall_cnt <= w_nxt_stall_cnt;
         r_lat_cnt   <= w_nxt_lat_cnt;
         r_rc_cnt    <= w_nxt_rc_cnt;
         r_m_read    <= w_nxt_m_read;
         r_m_address <= w_nxt_m_address;
         r_busy      <= w_nxt_busy;
         r_done      <= w_nxt_done;
         r_valid     <= w_nxt_valid;
         r_id_match  <= w_nxt_id_match;
         r_ts_match  <= w_nxt_ts_match;
         r_timeout   <= w_nxt_timeout;
         r_error     <= w_nxt_error;
         r_id_value  <= w_nxt_id_value;
         r_ts_value  <= w_nxt_ts_value;
      end
   end

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_auto      = r_auto;
      w_nxt_stall_cnt = r_stall_cnt;
      w_nxt_lat_cnt   = r_lat_cnt;
      w_nxt_rc_cnt    = r_rc_cnt;
      w_nxt_m_read    = r_m_read;
      w_nxt_m_address = r_m_address;
      w_nxt_busy      = r_busy;
      w_nxt_done      = 1'b0;
      w_nxt_valid     = r_valid;
      w_nxt_id_match  = r_id_match;
      w_nxt_ts_match  = r_ts_match;
      w_nxt_timeout   = r_timeout;
      w_nxt_error     = r_error;
      w_nxt_id_value  = r_id_value;
      w_nxt_ts_value  = r_ts_value;
      w_cap_id        = 1'b0;
      w_cap_ts        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start || r_auto || w_rc_hit) begin
               w_nxt_state     = S_RD_ID;
               w_nxt_auto      = 1'b0;
               w_nxt_rc_cnt    = '0;
               w_nxt_stall_cnt = '0;
               w_nxt_m_read    = 1'b1;
               w_nxt_m_address = 1'b0;
               w_nxt_busy      = 1'b1;
               w_nxt_valid     = 1'b0;
               w_nxt_id_match  = 1'b0;
               w_nxt_ts_match  = 1'b0;
               w_nxt_timeout   = 1'b0;
               w_nxt_error     = 1'b0;
               w_nxt_id_value  = '0;
               w_nxt_ts_value  = '0;
            end else if (RECHECK_EN && r_valid) begin
               w_nxt_rc_cnt = r_rc_cnt + RC_W'(1);
            end
         end
         S_RD_ID, S_RD_TS: begin
            if (r_m_read && m_waitrequest) begin
               // Slave stalled too long: abort and report with whatever was captured.
               if (r_stall_cnt == STALL_LAST) begin
                  w_nxt_state   = S_IDLE;
                  w_nxt_m_read  = 1'b0;
                  w_nxt_busy    = 1'b0;
                  w_nxt_done    = 1'b1;
                  w_nxt_valid   = 1'b1;
                  w_nxt_timeout = 1'b1;
                  w_nxt_error   = 1'b1;
               end else begin
                  w_nxt_stall_cnt = r_stall_cnt + STALL_W'(1);
               end
            end else if (r_m_read) begin
               if (!LAT_EN) begin
                  w_cap_id = (r_state == S_RD_ID);
                  w_cap_ts = (r_state == S_RD_TS);
               end else begin
                  w_nxt_m_read  = 1'b0;
                  w_nxt_lat_cnt = '0;
                  w_nxt_state   = (r_state == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
               end
            end
         end
         S_LAT_ID, S_LAT_TS: begin
            if (r_lat_cnt == LAT_LAST) begin
               w_cap_id = (r_state == S_LAT_ID);
               w_cap_ts = (r_state == S_LAT_TS);
            end else begin
               w_nxt_lat_cnt = r_lat_cnt + LAT_W'(1);
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase

      if (w_cap_id) begin
         w_nxt_id_value  = m_readdata;
         w_nxt_state     = S_RD_TS;
         w_nxt_m_read    = 1'b1;
         w_nxt_m_address = 1'b1;
         w_nxt_stall_cnt = '0;
      end

      // Timestamp is the last word: publish the verdict alongside it.
      if (w_cap_ts) begin
         w_nxt_ts_value = m_readdata;
         w_nxt_id_match = w_id_ok;
         w_nxt_ts_match = w_ts_ok;
         w_nxt_error    = ~(w_id_ok & w_ts_ok);
         w_nxt_valid    = 1'b1;
         w_nxt_done     = 1'b1;
         w_nxt_busy     = 1'b0;
         w_nxt_m_read   = 1'b0;
         w_nxt_state    = S_IDLE;
      end
   end

   assign m_read    = r_m_read;
   assign m_address = r_m_address;
   assign busy      = r_busy;
   assign done      = r_done;
   assign valid     = r_valid;
   assign id_match  = r_id_match;
   assign ts_match  = r_ts_match;
   assign timeout   = r_timeout;
   assign error     = r_error;
   assign id_value  = r_id_value;
   assign ts_value  = r_ts_value;

endmodule
